// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one AES decrypt core between two requesters.
// Round-robin grant in IDLE, level start/done handshake with the core in RUN,
// a watchdog that aborts a job the core never finishes, and a GAP state that
// holds START low until the core releases DONE.
module aes_job_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         REQ0_VALID,
    output logic         REQ0_READY,
    input  logic [127:0] REQ0_KEY,
    input  logic [127:0] REQ0_MSG_ENC,
    output logic         RSP0_VALID,
    output logic [127:0] RSP0_MSG_DEC,
    output logic         RSP0_ERR,
    input  logic         REQ1_VALID,
    output logic         REQ1_READY,
    input  logic [127:0] REQ1_KEY,
    input  logic [127:0] REQ1_MSG_ENC,
    output logic         RSP1_VALID,
    output logic [127:0] RSP1_MSG_DEC,
    output logic         RSP1_ERR,
    output logic         AES_START,
    input  logic         AES_DONE,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_ENC,
    input  logic [127:0] AES_MSG_DEC,
    output logic         BUSY,
    output logic         GRANT_ID
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_grant_id;
    logic               r_busy;
    logic               r_aes_start;
    logic [127:0]       r_key;
    logic [127:0]       r_msg_enc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rsp0_valid;
    logic [127:0]       r_rsp0_msg;
    logic               r_rsp0_err;
    logic               r_rsp1_valid;
    logic [127:0]       r_rsp1_msg;
    logic               r_rsp1_err;

    logic               w_idle;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_timeout;

    // READY is suppressed while RESET is asserted so no job slips in during reset
    assign w_idle    = (r_state == ST_IDLE) && !RESET;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Round-robin arbitration: on a tie the requester that did not own the last job wins
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (w_idle) begin
            w_ready0 = REQ0_VALID && (!REQ1_VALID || r_grant_id);
            w_ready1 = REQ1_VALID && (!REQ0_VALID || !r_grant_id);
        end else begin
            w_ready0 = 1'b0;
            w_ready1 = 1'b0;
        end
    end

    // Job FSM: accept, run the core with a watchdog, return the result, wait for DONE release
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= 1'b1;
            r_busy       <= 1'b0;
            r_aes_start  <= 1'b0;
            r_key        <= 128'd0;
            r_msg_enc    <= 128'd0;
            r_cnt        <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_msg   <= 128'd0;
            r_rsp0_err   <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_msg   <= 128'd0;
            r_rsp1_err   <= 1'b0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ready0 || w_ready1) begin
                        r_key       <= w_ready1 ? REQ1_KEY : REQ0_KEY;
                        r_msg_enc   <= w_ready1 ? REQ1_MSG_ENC : REQ0_MSG_ENC;
                        r_grant_id  <= w_ready1;
                        r_cnt       <= '0;
                        r_aes_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // DONE has priority over a watchdog expiry in the same cycle
                    if (AES_DONE) begin
                        if (r_grant_id) begin
                            r_rsp1_valid <= 1'b1;
                            r_rsp1_msg   <= AES_MSG_DEC;
                            r_rsp1_err   <= 1'b0;
                        end else begin
                            r_rsp0_valid <= 1'b1;
                            r_rsp0_msg   <= AES_MSG_DEC;
                            r_rsp0_err   <= 1'b0;
                        end
                        r_aes_start <= 1'b0;
                        r_state     <= ST_GAP;
                    end else if (w_timeout) begin
                        if (r_grant_id) begin
                            r_rsp1_valid <= 1'b1;
                            r_rsp1_msg   <= 128'd0;
                            r_rsp1_err   <= 1'b1;
                        end else begin
                            r_rsp0_valid <= 1'b1;
                            r_rsp0_msg   <= 128'd0;
                            r_rsp0_err   <= 1'b1;
                        end
                        r_aes_start <= 1'b0;
                        r_state     <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // Core keeps DONE until it has seen START low
                    if (!AES_DONE) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_aes_start <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ0_READY   = w_ready0;
    assign REQ1_READY   = w_ready1;
    assign RSP0_VALID   = r_rsp0_valid;
    assign RSP0_MSG_DEC = r_rsp0_msg;
    assign RSP0_ERR     = r_rsp0_err;
    assign RSP1_VALID   = r_rsp1_valid;
    assign RSP1_MSG_DEC = r_rsp1_msg;
    assign RSP1_ERR     = r_rsp1_err;
    assign AES_START    = r_aes_start;
    assign AES_KEY      = r_key;
    assign AES_MSG_ENC  = r_msg_enc;
    assign BUSY         = r_busy;
    assign GRANT_ID     = r_grant_id;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: randomized scoreboard bench for aes_job_arbiter with a
// behavioural AES core model and a timing-level reference model of the arbiter.
module tb_aes_job_arbiter;

    localparam int T = 16;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic         REQ0_READY, REQ1_READY;
    logic [127:0] REQ0_KEY = '0, REQ0_MSG_ENC = '0, REQ1_KEY = '0, REQ1_MSG_ENC = '0;
    logic         RSP0_VALID, RSP0_ERR, RSP1_VALID, RSP1_ERR;
    logic [127:0] RSP0_MSG_DEC, RSP1_MSG_DEC;
    logic         AES_START, AES_DONE = 1'b0;
    logic [127:0] AES_KEY, AES_MSG_ENC, AES_MSG_DEC = '0;
    logic         BUSY, GRANT_ID;

    aes_job_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_KEY(REQ0_KEY), .REQ0_MSG_ENC(REQ0_MSG_ENC),
        .RSP0_VALID(RSP0_VALID), .RSP0_MSG_DEC(RSP0_MSG_DEC), .RSP0_ERR(RSP0_ERR),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_KEY(REQ1_KEY), .REQ1_MSG_ENC(REQ1_MSG_ENC),
        .RSP1_VALID(RSP1_VALID), .RSP1_MSG_DEC(RSP1_MSG_DEC), .RSP1_ERR(RSP1_ERR),
        .AES_START(AES_START), .AES_DONE(AES_DONE), .AES_KEY(AES_KEY), .AES_MSG_ENC(AES_MSG_ENC),
        .AES_MSG_DEC(AES_MSG_DEC), .BUSY(BUSY), .GRANT_ID(GRANT_ID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int           rid;
        logic [127:0] msg;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         expq[$];
    int           dut_order[$];
    int           n_vec = 0, n_bad = 0;
    int           cyc = 0;
    logic         rst_q = 1'b0;
    bit           mon_en = 1'b0;
    logic [127:0] h_msg[2];
    logic         h_err[2];

    // stimulus / model state
    bit           want_rst = 1'b1, want0 = 1'b0, want1 = 1'b0;
    logic [127:0] key0 = '0, ct0 = '0, key1 = '0, ct1 = '0;
    int           m_idle = 0;
    bit           m_grant = 1'b1;
    int           n_acc = 0;
    int           core_delay = 10, core_hold = 0;

    // cycle index and registered view of RESET
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RESET;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Stand-in for AES: real vector for the FIPS job, a reversible scramble otherwise
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] c);
        if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
        return k ^ {c[63:0], c[127:64]};
    endfunction

    // Behavioural core: DONE core_delay cycles after START, held core_hold cycles after START falls
    initial begin
        int run_cnt = 0, hold_cnt = 0;
        forever begin
            @(negedge CLK);
            if (AES_START === 1'b1) begin
                run_cnt++;
                hold_cnt = 0;
                if (!AES_DONE && core_delay >= 0 && run_cnt == core_delay + 1) begin
                    AES_DONE    = 1'b1;
                    AES_MSG_DEC = core_fn(AES_KEY, AES_MSG_ENC);
                end
            end else begin
                run_cnt = 0;
                if (AES_DONE) begin
                    if (hold_cnt >= core_hold) begin
                        AES_DONE    = 1'b0;
                        AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
                    end else begin
                        hold_cnt++;
                    end
                end else begin
                    AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    task automatic mon_port(input int p, input logic v, input logic [127:0] m, input logic e);
        exp_t x;
        if (v === 1'b1) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp at cycle %0d: port %0d pulsed, required no pulse", cyc, p);
            end else begin
                x = expq.pop_front();
                chk("rsp_port", 128'(p), 128'(x.rid));
                chk("rsp_cycle", 128'(cyc), 128'(x.cyc));
                chk("rsp_msg", m, x.msg);
                chk("rsp_err", 128'(e), 128'(x.err));
                chk("rsp_start_low", 128'(AES_START), 128'(0));
                h_msg[p] = x.msg;
                h_err[p] = x.err;
            end
        end else begin
            chk("rsp_valid_low", 128'(v), 128'(0));
            chk("hold_msg", m, h_msg[p]);
            chk("hold_err", 128'(e), 128'(h_err[p]));
        end
    endtask

    // Monitor: pops expected responses on each RSP pulse and checks held values otherwise
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (rst_q === 1'b1) begin
                    chk("rst_start", 128'(AES_START), 128'(0));
                    chk("rst_busy", 128'(BUSY), 128'(0));
                    chk("rst_grant", 128'(GRANT_ID), 128'(1));
                    chk("rst_key", AES_KEY, 128'(0));
                    chk("rst_ct", AES_MSG_ENC, 128'(0));
                    chk("rst_rsp0", {RSP0_VALID, RSP0_ERR, RSP0_MSG_DEC[125:0]}, 128'(0));
                    chk("rst_rsp1", {RSP1_VALID, RSP1_ERR, RSP1_MSG_DEC[125:0]}, 128'(0));
                    chk("rst_rsp_hi", 128'({RSP0_MSG_DEC[127:126], RSP1_MSG_DEC[127:126]}), 128'(0));
                    h_msg[0] = '0; h_msg[1] = '0; h_err[0] = 1'b0; h_err[1] = 1'b0;
                end else begin
                    mon_port(0, RSP0_VALID, RSP0_MSG_DEC, RSP0_ERR);
                    mon_port(1, RSP1_VALID, RSP1_MSG_DEC, RSP1_ERR);
                end
            end
        end
    end

    // One cycle of stimulus plus the reference model's view of READY/BUSY/GRANT
    task automatic step();
        bit idle, e0, e1;
        int rid;
        logic [127:0] k, c;
        exp_t x;
        @(negedge CLK);
        RESET = want_rst;
        REQ0_VALID = want0; REQ0_KEY = key0; REQ0_MSG_ENC = ct0;
        REQ1_VALID = want1; REQ1_KEY = key1; REQ1_MSG_ENC = ct1;
        #1;
        idle = !want_rst && (cyc >= m_idle);
        e0 = idle && want0 && (!want1 || m_grant);
        e1 = idle && want1 && (!want0 || !m_grant);
        chk("ready0", 128'(REQ0_READY), 128'(e0));
        chk("ready1", 128'(REQ1_READY), 128'(e1));
        if (!want_rst) begin
            chk("busy", 128'(BUSY), 128'(cyc < m_idle));
            chk("grant_id", 128'(GRANT_ID), 128'(m_grant));
            if (REQ0_READY === 1'b1 && want0) dut_order.push_back(0);
            if (REQ1_READY === 1'b1 && want1) dut_order.push_back(1);
        end
        if (want_rst) begin
            m_grant = 1'b1;
            m_idle  = cyc + 1;
            expq.delete();
        end else if (e0 || e1) begin
            rid = e1 ? 1 : 0;
            k   = e1 ? key1 : key0;
            c   = e1 ? ct1 : ct0;
            x.rid = rid;
            if (core_delay >= 0 && core_delay <= T - 1) begin
                x.cyc = cyc + core_delay + 2;
                x.msg = core_fn(k, c);
                x.err = 1'b0;
                m_idle = x.cyc + 1 + core_hold;
            end else begin
                x.cyc = cyc + T + 1;
                x.msg = '0;
                x.err = 1'b1;
                m_idle = x.cyc + 1;
            end
            expq.push_back(x);
            m_grant = rid[0];
            n_acc++;
            if (e1) want1 = 1'b0; else want0 = 1'b0;
        end
    endtask

    task automatic arm(input int p);
        if (p == 0) begin
            want0 = 1'b1; key0 = {$urandom, $urandom, $urandom, $urandom}; ct0 = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            want1 = 1'b1; key1 = {$urandom, $urandom, $urandom, $urandom}; ct1 = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        want_rst = 1'b1; want0 = 1'b0; want1 = 1'b0;
        step();
        step();
        want_rst = 1'b0;
    endtask

    task automatic run_quiet();
        for (int k = 0; k < 400 && (want0 || want1 || cyc < m_idle); k++) step();
        chk("quiet_timeout", 128'({want0, want1, cyc < m_idle}), 128'(0));
        step();
    endtask

    initial begin
        int base;
        // reset from power-up
        want_rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        step();
        want_rst = 1'b0;

        // single FIPS-197 job on requester 0, DONE 10 cycles after START
        core_delay = 10; core_hold = 0;
        want0 = 1'b1; key0 = FIPS_KEY; ct0 = FIPS_CT;
        run_quiet();

        // both requesters held valid for 3 jobs from reset: order 0,1,0
        do_reset();
        dut_order.delete();
        core_delay = 4;
        arm(0); arm(1);
        base = n_acc;
        for (int k = 0; k < 200 && n_acc - base < 3; k++) begin
            step();
            if (n_acc - base < 3) begin
                if (!want0) arm(0);
                if (!want1) arm(1);
            end
        end
        want0 = 1'b0; want1 = 1'b0;
        run_quiet();
        chk("order_len", 128'(dut_order.size()), 128'(3));
        if (dut_order.size() >= 3) begin
            chk("order0", 128'(dut_order[0]), 128'(0));
            chk("order1", 128'(dut_order[1]), 128'(1));
            chk("order2", 128'(dut_order[2]), 128'(0));
        end

        // timeout: core never finishes
        core_delay = -1;
        arm(1);
        run_quiet();

        // DONE on the last count wins over the timeout
        core_delay = T - 1;
        arm(0);
        run_quiet();

        // stuck DONE: held 5 cycles after START falls, requester 0 waiting meanwhile
        core_delay = 3; core_hold = 5;
        arm(0);
        for (int k = 0; k < 50 && want0; k++) step();
        arm(0);
        run_quiet();

        // randomized traffic with drops, varied latency, timeouts and DONE hold
        for (int k = 0; k < 600; k++) begin
            if (cyc >= m_idle) begin
                core_delay = $urandom_range(0, 20);
                core_hold  = $urandom_range(0, 3);
            end
            if (!want0 && $urandom_range(0, 3) == 0) arm(0);
            else if (want0 && $urandom_range(0, 15) == 0) want0 = 1'b0;
            if (!want1 && $urandom_range(0, 3) == 0) arm(1);
            else if (want1 && $urandom_range(0, 15) == 0) want1 = 1'b0;
            step();
        end
        want0 = 1'b0; want1 = 1'b0;
        run_quiet();

        // reset 4 cycles into RUN drops the job, then a new job completes normally
        core_delay = 10; core_hold = 0;
        arm(0);
        for (int k = 0; k < 50 && want0; k++) step();
        for (int k = 0; k < 4; k++) step();
        want_rst = 1'b1;
        step();
        want_rst = 1'b0;
        step();
        step();
        arm(1);
        run_quiet();

        // drain any outstanding expectation
        for (int k = 0; k < 100 && expq.size() > 0; k++) step();
        chk("drain", 128'(expq.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
